// File: rtl/dl_cycle_report_unit.sv
// dl_cycle_report_unit: arbitrates one deadlock origin, debounces it over a confirm window
// and latches a single deadlock report (token_clear on false alarms).
module dl_cycle_report_unit #(
   parameter int PROC_NUM       = 2,
   parameter int CNT_W          = 16,
   parameter int CONFIRM_CYCLES = 16,
   parameter int IDX_W          = PROC_NUM > 1 ? $clog2(PROC_NUM) : 1
) (
   input  logic                      dl_clock,
   input  logic                      dl_reset,
   input  logic [PROC_NUM-1:0]       dl_in_vec,
   input  logic [PROC_NUM*CNT_W-1:0] trans_in_cnt_flat,
   input  logic [PROC_NUM*CNT_W-1:0] trans_out_cnt_flat,
   input  logic [PROC_NUM-1:0]       ap_done_reg_vec,
   input  logic                      report_ack,
   output logic                      dl_detect_out,
   output logic [PROC_NUM-1:0]       origin,
   output logic                      token_clear,
   output logic                      report_valid,
   output logic [IDX_W-1:0]          report_idx,
   output logic [CNT_W-1:0]          report_pending,
   output logic                      report_done_reg,
   output logic [31:0]               report_stall,
   output logic                      deadlock_fatal
);
   // ARM is the capture cycle: payload is loaded, report_valid rises one cycle later
   typedef enum logic [2:0] {IDLE, CONFIRM, CLEAR, ARM, REPORT, FATAL} state_t;
   state_t state, state_next;
   logic [IDX_W-1:0] k, k_pick;
   logic [31:0] confirm_cnt, stall_cnt, stall_inc;
   logic hit;

   always_comb begin
      k_pick = '0;
      for (int i = PROC_NUM - 1; i >= 0; i--)
         if (dl_in_vec[i]) k_pick = IDX_W'(i);
   end

   assign hit       = dl_in_vec[k];
   assign stall_inc = stall_cnt == '1 ? stall_cnt : stall_cnt + 32'd1;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = |dl_in_vec ? CONFIRM : IDLE;
         CONFIRM: state_next = !hit ? CLEAR : (confirm_cnt + 32'd1 >= 32'(CONFIRM_CYCLES) ? ARM : CONFIRM);
         CLEAR:   state_next = IDLE;
         ARM:     state_next = REPORT;
         REPORT:  state_next = report_ack ? FATAL : REPORT;
         default: state_next = state;
      endcase
   end

   always_ff @(posedge dl_clock or negedge dl_reset) begin
      if (!dl_reset) begin
         state           <= IDLE;
         k               <= '0;
         confirm_cnt     <= '0;
         stall_cnt       <= '0;
         report_idx      <= '0;
         report_pending  <= '0;
         report_done_reg <= 1'b0;
         report_stall    <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && |dl_in_vec) begin
            k           <= k_pick;
            confirm_cnt <= 32'd1;
            stall_cnt   <= 32'd1;
         end else if (state == CONFIRM && hit) begin
            confirm_cnt <= confirm_cnt + 32'd1;
            stall_cnt   <= stall_inc;
         end
         if (state == CONFIRM && state_next == ARM) begin
            report_idx      <= k;
            report_pending  <= trans_in_cnt_flat[k*CNT_W +: CNT_W] - trans_out_cnt_flat[k*CNT_W +: CNT_W];
            report_done_reg <= ap_done_reg_vec[k];
            report_stall    <= stall_inc;
         end
      end
   end

   assign dl_detect_out  = state inside {CONFIRM, ARM, REPORT, FATAL};
   assign origin         = dl_detect_out ? PROC_NUM'(1) << k : '0;
   assign token_clear    = state == CLEAR;
   assign report_valid   = state == REPORT;
   assign deadlock_fatal = state == FATAL;
endmodule

// File: doc/dl_cycle_report_unit.md
Name: dl_cycle_report_unit

Overview:
- Downstream consumer of the per-process deadlock-detect units in the simulation-only deadlock detector.
- Takes the per-process detect vector, arbitrates one origin process and asserts the global detect back to all units.
- Debounces persistence over a confirm window, issues token_clear on false alarms, and produces a single latched deadlock report with per-process transaction state.
- Testbench-side only; not synthesised into the design under test.

Parameters:
- PROC_NUM, 2, number of monitored processes (>=1)
- CNT_W, 16, width of each transaction counter
- CONFIRM_CYCLES, 16, cycles the origin's detect bit must stay high before a deadlock is declared (>=1)
- IDX_W, clog2(PROC_NUM) min 1, width of the process index

Ports:
- dl_clock  in  1  clock
- dl_reset  in  1  reset, asynchronous, active-low
- dl_in_vec  in  PROC_NUM  per-process local detect, already masked by all_finish upstream
- trans_in_cnt_flat  in  PROC_NUM*CNT_W  per-process start counts; process i at bits [i*CNT_W +: CNT_W]
- trans_out_cnt_flat  in  PROC_NUM*CNT_W  per-process done&continue counts; same packing
- ap_done_reg_vec  in  PROC_NUM  per-process done-but-not-continued flags
- report_ack  in  1  testbench consumes the report
- dl_detect_out  out  1  global detect, broadcast to all detect units
- origin  out  PROC_NUM  one-hot origin select for the token launch
- token_clear  out  1  one-cycle pulse that clears tokens in all detect units
- report_valid  out  1  report payload valid
- report_idx  out  IDX_W  origin process index
- report_pending  out  CNT_W  trans_in minus trans_out of the origin, modulo 2^CNT_W
- report_done_reg  out  1  ap_done_reg_vec bit of the origin
- report_stall  out  32  cycles from the detect assertion to report, saturating
- deadlock_fatal  out  1  level; deadlock confirmed and acknowledged

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0, confirm counter 0, stall counter 0.
- IDLE:
  - dl_in_vec==0: stay in IDLE.
  - Otherwise: the lowest set index k wins (priority; simultaneous bits resolve to lowest).
  - Next cycle: origin=one-hot(k), dl_detect_out=1, confirm counter=1, stall counter=1; go to CONFIRM.
- CONFIRM:
  - origin and dl_detect_out are held.
  - Each cycle with dl_in_vec[k]==1: confirm counter+1, stall counter+1 (saturate at 2^32-1).
  - Changes on other bits of dl_in_vec are ignored.
  - dl_in_vec[k]==0: go to CLEAR.
  - Confirm counter reaching CONFIRM_CYCLES with dl_in_vec[k] still 1: go to REPORT.
  - If dl_in_vec[k] drops in the same cycle the count would reach CONFIRM_CYCLES, the drop wins and the state goes to CLEAR.
- CLEAR (1 cycle):
  - token_clear=1, dl_detect_out=0, origin=0; then return to IDLE.
  - Re-arbitration happens only from IDLE, so there are at least 2 cycles between consecutive detect assertions.
- REPORT:
  - Payload is captured on entry and frozen:
    - report_idx=k
    - report_pending=(trans_in_cnt[k]-trans_out_cnt[k]) mod 2^CNT_W
    - report_done_reg=ap_done_reg_vec[k]
    - report_stall=stall counter
  - report_valid=1 from the cycle after entry; dl_detect_out and origin are held.
  - report_ack sampled while report_valid=1: go to FATAL.
  - report_ack while report_valid=0 is ignored.
  - dl_in_vec changes have no effect once in REPORT.
- FATAL (terminal until reset):
  - report_valid=0, deadlock_fatal=1.
  - dl_detect_out=1 and origin held; payload retained.
- Reset asserted in any state returns to IDLE immediately. No token_clear pulse is generated by reset.
- origin is either 0 or one-hot. dl_detect_out=1 exactly when state is CONFIRM, REPORT or FATAL.
- Latency from the first dl_in_vec bit to dl_detect_out is 1 cycle; to report_valid it is CONFIRM_CYCLES+1 cycles.

Test Plan:
- Reset, dl_in_vec=0 for 50 cycles -> all outputs remain 0.
- dl_in_vec=2'b10 held, trans_in[1]=5, trans_out[1]=3, ap_done_reg=2'b10 -> dl_detect_out=1 after 1 cycle, origin=2'b10; report_valid at cycle 17 with idx=1, pending=2, done_reg=1, stall=16; ack -> deadlock_fatal=1.
- dl_in_vec=2'b11 simultaneous -> origin=2'b01, idx=0.
- dl_in_vec[0] high 5 cycles then low -> token_clear single pulse, dl_detect_out back to 0, no report; re-assert -> new arbitration after the CLEAR cycle.
- trans_in[0]=0x0001, trans_out[0]=0xFFFF (wrap) -> pending=0x0002.
- dl_reset pulsed low during REPORT -> all outputs 0 asynchronously; restart detection works normally.
